redirect_ctrl: RTL

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

---
 rtl/redirect_ctrl_pkg.sv | 29 ++
 rtl/redirect_pend_buf.sv | 39 +++
 rtl/redirect_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/redirect_ctrl_pkg.sv
// Shared source/state encodings and counter helpers for the redirect controller.
// PC width comes from the `XLEN macro (64 unless defined by the build).
`ifndef XLEN
`define XLEN 64
`endif

package redirect_ctrl_pkg;

    // Source encoding doubles as priority rank: larger value wins.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_BPU    = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_TRAP   = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/redirect_pend_buf.sv
// Pending-redirect holding register: keeps one PC and its source rank while fetch is stalled.
// A new entry replaces the held one only when it ranks equal or higher.
module redirect_pend_buf
    import redirect_ctrl_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  src_e            i_src,
    output logic [XLEN-1:0] o_pc,
    output src_e            o_src,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    src_e            r_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= '0;
            r_src <= SRC_NONE;
        end else if (i_clear) begin
            r_pc  <= '0;
            r_src <= SRC_NONE;
        end else if (i_load && ((r_src == SRC_NONE) || (i_src >= r_src))) begin
            r_pc  <= i_pc;
            r_src <= i_src;
        end
    end

    assign o_pc    = r_pc;
    assign o_src   = r_src;
    assign o_valid = (r_src != SRC_NONE);

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect controller: arbitrates trap/branch/bpu redirects, parks them across stalls, and kills IF.
// Optional per-source issue counters are built only when REDIRECT_STAT_EN is defined.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = `XLEN,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] clint_pc_i,
    input  logic            clint_pc_valid_i,
    input  logic [XLEN-1:0] branch_pc_i,
    input  logic            branch_pc_valid_i,
    input  logic [XLEN-1:0] bpu_pc_i,
    input  logic            bpu_pc_valid_i,
    input  logic            stall_valid_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            redirect_valid_o,
    output logic [1:0]      redirect_src_o,
    output logic            flush_if_o,
    output logic            busy_o,
    output logic [31:0]     trap_cnt_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     bpu_cnt_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e          r_state;
    state_e          w_nextState;
    logic [2:0]      r_flushCnt;
    logic [2:0]      w_nextFlushCnt;

    logic [XLEN-1:0] w_candPc;
    src_e            w_candSrc;
    logic [XLEN-1:0] w_pendPc;
    src_e            w_pendSrc;
    logic            w_pendValid;

    logic            w_issue;
    logic [XLEN-1:0] w_issuePc;
    src_e            w_issueSrc;
    logic            w_fire;
    logic            w_load;
    logic            w_clear;

    always_comb begin
        w_candPc  = '0;
        w_candSrc = SRC_NONE;
        if (clint_pc_valid_i) begin
            w_candPc  = clint_pc_i;
            w_candSrc = SRC_TRAP;
        end else if (branch_pc_valid_i) begin
            w_candPc  = branch_pc_i;
            w_candSrc = SRC_BRANCH;
        end else if (bpu_pc_valid_i) begin
            w_candPc  = bpu_pc_i;
            w_candSrc = SRC_BPU;
        end
    end

    redirect_pend_buf #(
        .XLEN (XLEN)
    ) u_pend_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_pc    (w_candPc),
        .i_src   (w_candSrc),
        .o_pc    (w_pendPc),
        .o_src   (w_pendSrc),
        .o_valid (w_pendValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_flushCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_flushCnt <= w_nextFlushCnt;
        end
    end

    // Stall always parks the candidate; otherwise issue and (re)arm the flush window.
    always_comb begin
        w_nextState    = r_state;
        w_nextFlushCnt = r_flushCnt;
        w_issue        = 1'b0;
        w_issuePc      = '0;
        w_issueSrc     = SRC_NONE;
        w_load         = 1'b0;
        w_clear        = 1'b0;

        if (stall_valid_i) begin
            if (w_candSrc != SRC_NONE) begin
                w_load      = 1'b1;
                w_nextState = ST_PEND;
            end
        end else begin
            case (r_state)
                ST_PEND: begin
                    w_clear = 1'b1;
                    if (w_candSrc != SRC_NONE && (!w_pendValid || w_candSrc >= w_pendSrc)) begin
                        w_issue    = 1'b1;
                        w_issuePc  = w_candPc;
                        w_issueSrc = w_candSrc;
                    end else if (w_pendValid) begin
                        w_issue    = 1'b1;
                        w_issuePc  = w_pendPc;
                        w_issueSrc = w_pendSrc;
                    end
                    if (w_issue) begin
                        w_nextState    = ST_FLUSH;
                        w_nextFlushCnt = FLUSH_LOAD;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
                default: begin
                    if (w_candSrc != SRC_NONE) begin
                        w_issue        = 1'b1;
                        w_issuePc      = w_candPc;
                        w_issueSrc     = w_candSrc;
                        w_nextState    = ST_FLUSH;
                        w_nextFlushCnt = FLUSH_LOAD;
                    end else if (r_state == ST_FLUSH) begin
                        w_nextFlushCnt = r_flushCnt - 3'd1;
                        if (r_flushCnt <= 3'd1) begin
                            w_nextState    = ST_IDLE;
                            w_nextFlushCnt = '0;
                        end
                    end
                end
            endcase
        end
    end

    assign w_fire           = w_issue & ~rst;
    assign redirect_valid_o = w_fire;
    assign redirect_pc_o    = w_fire ? w_issuePc : '0;
    assign redirect_src_o   = w_fire ? w_issueSrc : SRC_NONE;
    assign flush_if_o       = (r_state == ST_FLUSH);
    assign busy_o           = (r_state != ST_IDLE);

`ifdef REDIRECT_STAT_EN
    logic [31:0] r_trapCnt;
    logic [31:0] r_branchCnt;
    logic [31:0] r_bpuCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trapCnt   <= '0;
            r_branchCnt <= '0;
            r_bpuCnt    <= '0;
        end else if (w_issue) begin
            if (w_issueSrc == SRC_TRAP)   r_trapCnt   <= satInc(r_trapCnt);
            if (w_issueSrc == SRC_BRANCH) r_branchCnt <= satInc(r_branchCnt);
            if (w_issueSrc == SRC_BPU)    r_bpuCnt    <= satInc(r_bpuCnt);
        end
    end

    assign trap_cnt_o   = r_trapCnt;
    assign branch_cnt_o = r_branchCnt;
    assign bpu_cnt_o    = r_bpuCnt;
`else
    assign trap_cnt_o   = '0;
    assign branch_cnt_o = '0;
    assign bpu_cnt_o    = '0;
`endif

endmodule
